// File: rtl/apx_float_accumulator.sv
// Stream-reduction front end for an external stb/ack float adder: folds a
// last-terminated stream of singles into one sum and reports it with the element count.
module apx_float_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      input_x,
    input  logic             input_x_last,
    input  logic             input_x_stb,
    output logic             input_x_ack,
    output logic [31:0]      adder_a,
    output logic             adder_a_stb,
    input  logic             adder_a_ack,
    output logic [31:0]      adder_b,
    output logic             adder_b_stb,
    input  logic             adder_b_ack,
    input  logic [31:0]      adder_z,
    input  logic             adder_z_stb,
    output logic             adder_z_ack,
    output logic [31:0]      output_z,
    output logic [CNT_W-1:0] output_count,
    output logic             output_z_stb,
    input  logic             output_z_ack
);

    typedef enum logic [2:0] {
        GET_FIRST,
        GET_X,
        SEND_A,
        SEND_B,
        WAIT_Z,
        PUT_Z
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [31:0]        sum_q, sum_d;
    logic [31:0]        elem_q, elem_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               last_q, last_d;
    logic               in_ack_q, in_ack_d;
    logic [31:0]        adder_a_q, adder_a_d;
    logic               a_stb_q, a_stb_d;
    logic [31:0]        adder_b_q, adder_b_d;
    logic               b_stb_q, b_stb_d;
    logic               z_ack_q, z_ack_d;
    logic [31:0]        out_z_q, out_z_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               out_stb_q, out_stb_d;

    // Each state raises its stb/ack one cycle after entry and drops it on the
    // transfer edge, so at most one handshake line is ever high.
    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        elem_d    = elem_q;
        count_d   = count_q;
        last_d    = last_q;
        in_ack_d  = in_ack_q;
        adder_a_d = adder_a_q;
        a_stb_d   = a_stb_q;
        adder_b_d = adder_b_q;
        b_stb_d   = b_stb_q;
        z_ack_d   = z_ack_q;
        out_z_d   = out_z_q;
        out_cnt_d = out_cnt_q;
        out_stb_d = out_stb_q;
        case (state_q)
            GET_FIRST: begin
                in_ack_d = 1'b1;
                if (in_ack_q && input_x_stb) begin
                    sum_d    = input_x;
                    count_d  = CNT_ONE;
                    last_d   = input_x_last;
                    in_ack_d = 1'b0;
                    state_d  = input_x_last ? PUT_Z : GET_X;
                end
            end
            GET_X: begin
                in_ack_d = 1'b1;
                if (in_ack_q && input_x_stb) begin
                    elem_d   = input_x;
                    last_d   = input_x_last;
                    count_d  = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
                    in_ack_d = 1'b0;
                    state_d  = SEND_A;
                end
            end
            SEND_A: begin
                adder_a_d = sum_q;
                a_stb_d   = 1'b1;
                if (a_stb_q && adder_a_ack) begin
                    a_stb_d = 1'b0;
                    state_d = SEND_B;
                end
            end
            SEND_B: begin
                adder_b_d = elem_q;
                b_stb_d   = 1'b1;
                if (b_stb_q && adder_b_ack) begin
                    b_stb_d = 1'b0;
                    state_d = WAIT_Z;
                end
            end
            WAIT_Z: begin
                z_ack_d = 1'b1;
                if (z_ack_q && adder_z_stb) begin
                    sum_d   = adder_z;
                    z_ack_d = 1'b0;
                    state_d = last_q ? PUT_Z : GET_X;
                end
            end
            PUT_Z: begin
                // sum and count are frozen here, so the output registers hold steady
                out_z_d   = sum_q;
                out_cnt_d = count_q;
                out_stb_d = 1'b1;
                if (out_stb_q && output_z_ack) begin
                    out_stb_d = 1'b0;
                    state_d   = GET_FIRST;
                end
            end
            default: state_d = GET_FIRST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= GET_FIRST;
            sum_q     <= '0;
            elem_q    <= '0;
            count_q   <= '0;
            last_q    <= 1'b0;
            in_ack_q  <= 1'b0;
            adder_a_q <= '0;
            a_stb_q   <= 1'b0;
            adder_b_q <= '0;
            b_stb_q   <= 1'b0;
            z_ack_q   <= 1'b0;
            out_z_q   <= '0;
            out_cnt_q <= '0;
            out_stb_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            elem_q    <= elem_d;
            count_q   <= count_d;
            last_q    <= last_d;
            in_ack_q  <= in_ack_d;
            adder_a_q <= adder_a_d;
            a_stb_q   <= a_stb_d;
            adder_b_q <= adder_b_d;
            b_stb_q   <= b_stb_d;
            z_ack_q   <= z_ack_d;
            out_z_q   <= out_z_d;
            out_cnt_q <= out_cnt_d;
            out_stb_q <= out_stb_d;
        end
    end

    assign input_x_ack  = in_ack_q;
    assign adder_a      = adder_a_q;
    assign adder_a_stb  = a_stb_q;
    assign adder_b      = adder_b_q;
    assign adder_b_stb  = b_stb_q;
    assign adder_z_ack  = z_ack_q;
    assign output_z     = out_z_q;
    assign output_count = out_cnt_q;
    assign output_z_stb = out_stb_q;

endmodule
